sirv_plic_gen: RTL and testbench

- Parametrised platform-level interrupt controller, next generation of the fixed 18-source PLIC wrapper.
- Single ICB slave port for register access, N interrupt sources, one hart-context interrupt output.
- Adds per-source edge/level trigger mode, a one-deep edge latch, and a configurable response register.
- Sits on the peripheral ICB bus; its output drives the core external-interrupt input.

---
 rtl/sirv_plic_gen_if.sv | 22 ++
 rtl/sirv_plic_gen.sv | 181 ++++++++++++++++++
 tb/tb_sirv_plic_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sirv_plic_gen_if.sv
// ICB register-access bundle for the PLIC: command channel in, response channel out.
// master drives commands and response ready; slave answers with ready, valid and read data.
interface sirv_plic_gen_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [23:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata
    );
endinterface

// File: rtl/sirv_plic_gen.sv
// Parametrised PLIC: per-source level/edge gateway, priority arbitration, claim/complete over ICB.
// Optional macro PLIC_IRQ_SYNC_EN inserts a 2-flop synchroniser on plic_irq_i ahead of the gateway.
module sirv_plic_gen #(
    parameter int IRQ_NUM    = 18,
    parameter int PRIO_WIDTH = 3,
    parameter int ID_WIDTH   = 5,
    parameter int RSP_FLOP   = 1
) (
    input  logic                clk,
    input  logic                rst,
    sirv_plic_gen_if.slave      icb,
    input  logic [IRQ_NUM-1:0]  plic_irq_i,
    output logic                plic_irq_o
);

    localparam logic [21:0] W_PEND  = 22'h000400;
    localparam logic [21:0] W_TRIG  = 22'h000420;
    localparam logic [21:0] W_EN    = 22'h000800;
    localparam logic [21:0] W_THR   = 22'h080000;
    localparam logic [21:0] W_CLAIM = 22'h080001;

    logic [PRIO_WIDTH-1:0] prio [IRQ_NUM];
    logic [PRIO_WIDTH-1:0] threshold;
    logic [IRQ_NUM-1:0]    pending, enable, trig, in_service, edge_lat, prev;
    logic [IRQ_NUM-1:0]    pend_n, isv_n, lat_n;
    logic [IRQ_NUM-1:0]    src_raw, src;
    logic [ID_WIDTH-1:0]   winner, cmpl_id;
    logic [PRIO_WIDTH-1:0] best;
    logic [31:0]           rd_data;
    logic [21:0]           word;
    logic                  cmd_accept, wr_accept;
    logic                  claim_rd, cmpl_wr, prio_wr, en_wr, trig_wr, thr_wr;
    logic                  unused_bits;

`ifdef PLIC_IRQ_SYNC_EN
    logic [IRQ_NUM-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= plic_irq_i;
            sync2 <= sync1;
        end
    end

    assign src_raw = sync2;
`else
    assign src_raw = plic_irq_i;
`endif

    assign src         = {src_raw[IRQ_NUM-1:1], 1'b0};
    assign word        = icb.icb_cmd_addr[23:2];
    assign cmd_accept  = icb.icb_cmd_valid && icb.icb_cmd_ready;
    assign wr_accept   = cmd_accept && !icb.icb_cmd_read;
    assign claim_rd    = cmd_accept && icb.icb_cmd_read && (word == W_CLAIM);
    assign cmpl_wr     = wr_accept && (word == W_CLAIM);
    assign prio_wr     = wr_accept && (word < 22'(IRQ_NUM));
    assign en_wr       = wr_accept && (word == W_EN);
    assign trig_wr     = wr_accept && (word == W_TRIG);
    assign thr_wr      = wr_accept && (word == W_THR);
    assign cmpl_id     = icb.icb_cmd_wdata[ID_WIDTH-1:0];
    assign unused_bits = ^{icb.icb_cmd_addr[1:0], icb.icb_cmd_wdata, src_raw[0],
                           prev[0], in_service[0], edge_lat[0]};

    // Descending scan with >= lets the lowest ID win a priority tie.
    always_comb begin
        winner = '0;
        best   = '0;
        for (int i = IRQ_NUM - 1; i >= 1; i--) begin
            if (enable[i] && pending[i] && (prio[i] > threshold) && (prio[i] >= best)) begin
                winner = ID_WIDTH'(i);
                best   = prio[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (word == 22'(i)) rd_data = 32'(prio[i]);
        end
        case (word)
            W_PEND:  rd_data = 32'(pending);
            W_TRIG:  rd_data = 32'(trig);
            W_EN:    rd_data = 32'(enable);
            W_THR:   rd_data = 32'(threshold);
            W_CLAIM: rd_data = 32'(winner);
            default: ;
        endcase
    end

    // Gateway first, then claim/complete override it; in-service blocks re-pending until complete.
    always_comb begin
        pend_n = pending;
        isv_n  = in_service;
        lat_n  = edge_lat;
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (trig[i]) begin
                if (src[i] && !prev[i]) begin
                    if (!pending[i] && !in_service[i]) pend_n[i] = 1'b1;
                    else                               lat_n[i]  = 1'b1;
                end
            end else if (src[i] && !pending[i] && !in_service[i]) begin
                pend_n[i] = 1'b1;
            end
            if (claim_rd && (winner == ID_WIDTH'(i))) begin
                pend_n[i] = 1'b0;
                isv_n[i]  = 1'b1;
            end
            if (cmpl_wr && (cmpl_id == ID_WIDTH'(i)) && in_service[i]) begin
                isv_n[i] = 1'b0;
                if (edge_lat[i]) begin
                    pend_n[i] = 1'b1;
                    lat_n[i]  = 1'b0;
                end
            end
        end
        if (trig_wr) lat_n = '0;
        pend_n[0] = 1'b0;
        isv_n[0]  = 1'b0;
        lat_n[0]  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IRQ_NUM; i++) prio[i] <= '0;
            threshold  <= '0;
            pending    <= '0;
            enable     <= '0;
            trig       <= '0;
            in_service <= '0;
            edge_lat   <= '0;
            prev       <= '0;
            plic_irq_o <= 1'b0;
        end else begin
            pending    <= pend_n;
            in_service <= isv_n;
            edge_lat   <= lat_n;
            prev       <= src;
            plic_irq_o <= (winner != '0);
            if (prio_wr) begin
                for (int i = 1; i < IRQ_NUM; i++) begin
                    if (word == 22'(i)) prio[i] <= icb.icb_cmd_wdata[PRIO_WIDTH-1:0];
                end
            end
            if (en_wr)   enable    <= {icb.icb_cmd_wdata[IRQ_NUM-1:1], 1'b0};
            if (trig_wr) trig      <= {icb.icb_cmd_wdata[IRQ_NUM-1:1], 1'b0};
            if (thr_wr)  threshold <= icb.icb_cmd_wdata[PRIO_WIDTH-1:0];
        end
    end

    generate
        if (RSP_FLOP != 0) begin : g_rsp_flop
            logic        rsp_valid_q;
            logic [31:0] rsp_rdata_q;

            assign icb.icb_cmd_ready = !rsp_valid_q || icb.icb_rsp_ready;
            assign icb.icb_rsp_valid = rsp_valid_q;
            assign icb.icb_rsp_rdata = rsp_rdata_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                end else if (cmd_accept) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= icb.icb_cmd_read ? rd_data : 32'h0;
                end else if (icb.icb_rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end else begin : g_rsp_comb
            assign icb.icb_cmd_ready = icb.icb_rsp_ready;
            assign icb.icb_rsp_valid = icb.icb_cmd_valid && !rst;
            assign icb.icb_rsp_rdata = (icb.icb_cmd_read && !rst) ? rd_data : 32'h0;
        end
    endgenerate

endmodule

// File: tb/tb_sirv_plic_gen.sv
// Scoreboard bench for sirv_plic_gen: expected read data is queued at command issue and
// compared when the response handshake completes; interrupt output is checked directly.
module tb_sirv_plic_gen;
    localparam int IRQ_NUM = 18;
`ifdef PLIC_IRQ_SYNC_EN
    localparam int SRC_LAT = 2;
`else
    localparam int SRC_LAT = 0;
`endif
    localparam logic [23:0] A_PEND  = 24'h001000;
    localparam logic [23:0] A_TRIG  = 24'h001080;
    localparam logic [23:0] A_EN    = 24'h002000;
    localparam logic [23:0] A_THR   = 24'h200000;
    localparam logic [23:0] A_CLAIM = 24'h200004;

    logic               clk = 1'b0;
    logic               rst;
    logic [IRQ_NUM-1:0] irq;
    logic               irqOut;
    int                 vectors = 0;
    int                 miscompares = 0;
    logic [31:0]        expQ[$];
    string              tagQ[$];
    logic [31:0]        monExp;
    string              monTag;

    sirv_plic_gen_if icb();

    sirv_plic_gen #(
        .IRQ_NUM(IRQ_NUM), .PRIO_WIDTH(3), .ID_WIDTH(5), .RSP_FLOP(1)
    ) dut (
        .clk(clk), .rst(rst), .icb(icb), .plic_irq_i(irq), .plic_irq_o(irqOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command, queues its expected response, returns just after the accepting edge.
    task automatic applyStimulus(input logic rd, input logic [23:0] a, input logic [31:0] wd,
                                 input logic [31:0] exp, input string tag);
        int waitCnt = 0;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = wd;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        #1;
        while (!icb.icb_cmd_ready && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (waitCnt >= 50) checkOutput({tag, "_cmd_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
    endtask

    task automatic regWrite(input logic [23:0] a, input logic [31:0] wd);
        applyStimulus(1'b0, a, wd, 32'h0, "write_rdata");
    endtask

    task automatic regRead(input logic [23:0] a, input logic [31:0] exp, input string tag);
        applyStimulus(1'b1, a, 32'h0, exp, tag);
    endtask

    task automatic pulse4();
        irq[4] = 1'b1;
        tick();
        irq[4] = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst && icb.icb_rsp_valid && icb.icb_rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                monTag = tagQ.pop_front();
                checkOutput(monTag, icb.icb_rsp_rdata, monExp);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        irq = '0;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(icb.icb_rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", icb.icb_rsp_rdata, 32'd0);
        checkOutput("rst_irq_o", 32'(irqOut), 32'd0);
        tick();
        rst = 1'b0;

        regRead(A_PEND, 32'h0, "rst_pending");
        regRead(A_EN, 32'h0, "rst_enable");
        regRead(A_CLAIM, 32'h0, "rst_claim");
        @(negedge clk);
        checkOutput("rst_irq_o_idle", 32'(irqOut), 32'd0);
        tick();

        $display("[TB] level source 3");
        regWrite(24'h00000C, 32'd2);
        regWrite(A_EN, 32'h8);
        regWrite(A_THR, 32'd1);
        irq[3] = 1'b1;
        repeat (SRC_LAT) tick();
        @(negedge clk);
        checkOutput("lvl_irq_o_0cyc", 32'(irqOut), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lvl_irq_o_1cyc", 32'(irqOut), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("lvl_irq_o_2cyc", 32'(irqOut), 32'd1);
        tick();
        regRead(A_CLAIM, 32'd3, "lvl_claim");
        tick();
        @(negedge clk);
        checkOutput("lvl_irq_o_drop", 32'(irqOut), 32'd0);
        tick();
        regRead(A_PEND, 32'h0, "lvl_pend_in_service");
        regWrite(A_CLAIM, 32'd3);
        tick();
        regRead(A_PEND, 32'h8, "lvl_repend");
        irq[3] = 1'b0;
        repeat (2 + SRC_LAT) tick();
        regRead(A_CLAIM, 32'd3, "lvl_claim2");
        regWrite(A_CLAIM, 32'd3);
        regRead(A_PEND, 32'h0, "lvl_clean");

        $display("[TB] arbitration 2/5/7");
        regWrite(24'h000008, 32'd4);
        regWrite(24'h000014, 32'd4);
        regWrite(24'h00001C, 32'd4);
        regWrite(A_EN, 32'h000000A4);
        irq[2] = 1'b1;
        irq[5] = 1'b1;
        irq[7] = 1'b1;
        repeat (2 + SRC_LAT) tick();
        regRead(A_CLAIM, 32'd2, "arb_tie_lowest_id");
        regWrite(24'h000014, 32'd6);
        regRead(24'h000014, 32'd6, "arb_prio5_readback");
        regRead(A_CLAIM, 32'd5, "arb_higher_prio");
        regWrite(A_THR, 32'd6);
        regRead(A_CLAIM, 32'd0, "arb_threshold_none");
        tick();
        @(negedge clk);
        checkOutput("arb_irq_o_off", 32'(irqOut), 32'd0);
        tick();
        irq[2] = 1'b0;
        irq[5] = 1'b0;
        irq[7] = 1'b0;
        repeat (2 + SRC_LAT) tick();
        regWrite(A_CLAIM, 32'd2);
        regWrite(A_CLAIM, 32'd5);
        regWrite(A_THR, 32'd1);
        regRead(A_CLAIM, 32'd7, "arb_remaining");
        regWrite(A_CLAIM, 32'd7);
        regRead(A_PEND, 32'h0, "arb_clean");

        $display("[TB] edge source 4");
        regWrite(A_EN, 32'h10);
        regWrite(24'h000010, 32'd3);
        regWrite(A_TRIG, 32'h10);
        pulse4();
        repeat (SRC_LAT) tick();
        regRead(A_CLAIM, 32'd4, "edge_claim");
        pulse4();
        pulse4();
        repeat (SRC_LAT) tick();
        regRead(A_PEND, 32'h0, "edge_pend_in_service");
        regWrite(A_CLAIM, 32'd4);
        regRead(A_PEND, 32'h10, "edge_latch_repend");
        regRead(A_CLAIM, 32'd4, "edge_claim2");
        regWrite(A_CLAIM, 32'd4);
        regRead(A_PEND, 32'h0, "edge_single_latch");

        $display("[TB] response backpressure");
        tick();
        icb.icb_rsp_ready = 1'b0;
        regRead(A_TRIG, 32'h10, "stall_rdata");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_cmd_ready", 32'(icb.icb_cmd_ready), 32'd0);
            checkOutput("stall_rdata_hold", icb.icb_rsp_rdata, 32'h10);
        end
        tick();
        icb.icb_rsp_ready = 1'b1;
        #1;
        checkOutput("release_cmd_ready", 32'(icb.icb_cmd_ready), 32'd1);
        regRead(A_EN, 32'h10, "release_read");

        $display("[TB] ignored completes");
        pulse4();
        repeat (SRC_LAT) tick();
        regWrite(A_CLAIM, 32'd0);
        regWrite(A_CLAIM, 32'd31);
        regWrite(A_CLAIM, 32'd4);
        regRead(A_PEND, 32'h10, "cmpl_ignored_pend");
        regRead(A_CLAIM, 32'd4, "cmpl_ignored_claim");

        $display("[TB] reset mid-response");
        tick();
        icb.icb_rsp_ready = 1'b0;
        regRead(24'h00000C, 32'd2, "dropped_rsp");
        rst = 1'b1;
        expQ.delete();
        tagQ.delete();
        tick();
        @(negedge clk);
        checkOutput("midrst_rsp_valid", 32'(icb.icb_rsp_valid), 32'd0);
        checkOutput("midrst_rsp_rdata", icb.icb_rsp_rdata, 32'd0);
        checkOutput("midrst_irq_o", 32'(irqOut), 32'd0);
        tick();
        rst = 1'b0;
        icb.icb_rsp_ready = 1'b1;
        regRead(24'h00000C, 32'd0, "midrst_prio3");
        regRead(A_TRIG, 32'd0, "midrst_trig");
        regRead(A_PEND, 32'd0, "midrst_pend");

        begin
            int n = 0;
            while (expQ.size() != 0 && n < 50) begin
                tick();
                n++;
            end
            if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
